period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 140 ++++++++++++++
 tb/tb_period_meter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous input in clk_ref cycles, with a sticky timeout.
// Define PERIOD_METER_AVG_EN to report the truncated average of every 4 consecutive periods instead.
module period_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic             meta_q, sync_q, prev_q;
  logic             rise;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, hcnt_q, period_q, high_q;
  logic [CNT_W-1:0] cnt_d, hcnt_d;
  logic             vld_q, tmo_q;

  // NOTE: reset is synchronous, so it lives inside the clocked block and is only seen on an edge.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sig_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

  always_comb begin
    cnt_d  = cnt_q + ONE;
    hcnt_d = hcnt_q + CNT_W'(sync_q);
  end

`ifdef PERIOD_METER_AVG_EN
  logic [1:0]       grp_q;
  logic [CNT_W+1:0] psum_q, hsum_q, psum_d, hsum_d;

  assign psum_d = psum_q + (CNT_W+2)'(cnt_q);
  assign hsum_d = hsum_q + (CNT_W+2)'(hcnt_q);
`endif

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      vld_q    <= 1'b0;
      tmo_q    <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      grp_q    <= '0;
      psum_q   <= '0;
      hsum_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it for one cycle.
      vld_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
`ifdef PERIOD_METER_AVG_EN
        grp_q   <= '0;
        psum_q  <= '0;
        hsum_q  <= '0;
`endif
      end else begin
        unique case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (rise) begin
              cnt_q   <= ONE;
              hcnt_q  <= CNT_W'(sync_q);
              state_q <= MEAS;
            end
          end
          MEAS: begin
            // A rise beats the timeout when both land on the same cycle.
            if (rise) begin
              cnt_q  <= ONE;
              hcnt_q <= ONE;
`ifdef PERIOD_METER_AVG_EN
              if (grp_q == 2'd3) begin
                period_q <= psum_d[CNT_W+1:2];
                high_q   <= hsum_d[CNT_W+1:2];
                vld_q    <= 1'b1;
                tmo_q    <= 1'b0;
                grp_q    <= '0;
                psum_q   <= '0;
                hsum_q   <= '0;
              end else begin
                grp_q  <= grp_q + 2'd1;
                psum_q <= psum_d;
                hsum_q <= hsum_d;
              end
`else
              period_q <= cnt_q;
              high_q   <= hcnt_q;
              vld_q    <= 1'b1;
              tmo_q    <= 1'b0;
`endif
            end else if (cnt_q == TIMEOUT_C) begin
              tmo_q   <= 1'b1;
              state_q <= ARM;
`ifdef PERIOD_METER_AVG_EN
              grp_q   <= '0;
              psum_q  <= '0;
              hsum_q  <= '0;
`endif
            end else begin
              cnt_q  <= cnt_d;
              hcnt_q <= hcnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign period_vld = vld_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: waveforms are built as lists of (high, low) periods and the
// expected reports are derived from the rise-to-rise intervals, skipping the arming rise.
module tb_period_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 100;

  logic             clk_ref = 1'b0;
  logic             rst     = 1'b1;
  logic             sig_in  = 1'b0;
  logic             en      = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             period_vld, timeout;

  typedef struct {
    int p;
    int h;
    bit t;
  } meas_t;

  meas_t obs_q[$];
  meas_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .sig_in     (sig_in),
    .en         (en),
    .period     (period),
    .high_time  (high_time),
    .period_vld (period_vld),
    .timeout    (timeout)
  );

  always #5 clk_ref = ~clk_ref;

  // Record every reported measurement, sampled away from the active edge.
  always @(negedge clk_ref) begin
    if (period_vld === 1'b1) begin
      meas_t m;
      m.p = int'(period);
      m.h = int'(high_time);
      m.t = timeout;
      obs_q.push_back(m);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic meas_t mk(input int p, input int h);
    meas_t m;
    m.p = p;
    m.h = h;
    m.t = 1'b0;
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ref);
    #1;
  endtask

  task automatic do_reset();
    sig_in = 1'b0;
    en     = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse(input int h, input int l);
    sig_in = 1'b1;
    tick(h);
    sig_in = 1'b0;
    tick(l);
  endtask

  task automatic final_rise();
    sig_in = 1'b1;
    tick(2);
    sig_in = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    en     = 1'b1;
    sig_in = 1'b1;
    rst    = 1'b1;
    tick(2);
    @(negedge clk_ref);
    n_vec++;
    if (period !== '0) begin n_err++; $display("FAIL reset_period: got %0d, required 0", period); end
    n_vec++;
    if (high_time !== '0) begin n_err++; $display("FAIL reset_high: got %0d, required 0", high_time); end
    n_vec++;
    if (period_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b, required 0", period_vld); end
    n_vec++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_div20();
    do_reset();
    en = 1'b1;
    tick(2);
    repeat (6) begin pulse(10, 10); exp_q.push_back(mk(20, 10)); end
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL div20[%0d]: no period_vld, required period=%0d high=%0d", i, exp_q[i].p, exp_q[i].h);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL div20[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL div20_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1;
    tick(2);
    for (int k = 0; k < 12; k++) begin
      int h, l;
      h = int'($urandom_range(1, 25));
      l = int'($urandom_range(1, 25));
      pulse(h, l);
      exp_q.push_back(mk(h + l, h));
    end
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL random[%0d]: no period_vld, required period=%0d high=%0d", i, exp_q[i].p, exp_q[i].h);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL random[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL random_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1;
    tick(2);
    repeat (2) begin pulse(10, 10); exp_q.push_back(mk(20, 10)); end
    sig_in = 1'b1;
    tick(10);
    sig_in = 1'b0;
    tick(80);
    @(negedge clk_ref);
    n_vec++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b, required 0", timeout); end
    tick(20);
    @(negedge clk_ref);
    n_vec++;
    if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b, required 1", timeout); end
    n_vec++;
    if (period !== 16'd20 || high_time !== 16'd10) begin
      n_err++; $display("FAIL timeout_hold: got period=%0d high=%0d, required 20/10", period, high_time);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL timeout_pre_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    obs_q.delete();
    exp_q.delete();
    repeat (3) begin pulse(10, 10); exp_q.push_back(mk(20, 10)); end
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL timeout_restart[%0d]: no period_vld, required period=%0d", i, exp_q[i].p);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL timeout_restart[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL timeout_restart_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_coincident();
    do_reset();
    en = 1'b1;
    tick(2);
    repeat (3) begin pulse(TMO / 2, TMO / 2); exp_q.push_back(mk(TMO, TMO / 2)); end
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL coincident[%0d]: no period_vld, required period=%0d", i, exp_q[i].p);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL coincident[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL coincident_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    n_vec++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL coincident_timeout: got %b, required 0", timeout); end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    tick(2);
    repeat (3) begin pulse(12, 8); exp_q.push_back(mk(20, 12)); end
    sig_in = 1'b1;
    tick(5);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      @(negedge clk_ref);
      n_vec++;
      if (period !== 16'd20 || high_time !== 16'd12 || period_vld !== 1'b0) begin
        n_err++; $display("FAIL en_drop_hold[%0d]: got period=%0d high=%0d vld=%b, required 20/12/0",
                          i, period, high_time, period_vld);
      end
    end
    en = 1'b1;
    tick(2);
    sig_in = 1'b0;
    tick(8);
    repeat (2) begin pulse(12, 8); exp_q.push_back(mk(20, 12)); end
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL en_drop[%0d]: no period_vld, required period=%0d", i, exp_q[i].p);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL en_drop[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL en_drop_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    tick(2);
    repeat (2) begin pulse(10, 10); exp_q.push_back(mk(20, 10)); end
    sig_in = 1'b1;
    tick(10);
    sig_in = 1'b0;
    tick(4);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rst_mid_pre_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk_ref);
    n_vec++;
    if (period !== '0 || high_time !== '0 || period_vld !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_clear: got period=%0d high=%0d vld=%b timeout=%b, required all 0",
                        period, high_time, period_vld, timeout);
    end
    obs_q.delete();
    exp_q.delete();
    tick(6);
    repeat (2) begin pulse(10, 10); exp_q.push_back(mk(20, 10)); end
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL rst_mid[%0d]: no period_vld, required period=%0d", i, exp_q[i].p);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL rst_mid[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rst_mid_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

`ifdef PERIOD_METER_AVG_EN
  task automatic test_avg();
    int hs[4] = '{9, 10, 11, 10};
    int ls[4] = '{9, 10, 11, 11};
    int psum, hsum;
    do_reset();
    en = 1'b1;
    tick(2);
    psum = 0;
    hsum = 0;
    for (int i = 0; i < 4; i++) begin
      pulse(hs[i], ls[i]);
      psum += hs[i] + ls[i];
      hsum += hs[i];
    end
    exp_q.push_back(mk(psum / 4, hsum / 4));
    final_rise();
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= obs_q.size()) begin
        n_err++; $display("FAIL avg[%0d]: no period_vld, required period=%0d", i, exp_q[i].p);
      end else if (obs_q[i].p !== exp_q[i].p || obs_q[i].h !== exp_q[i].h || obs_q[i].t !== 1'b0) begin
        n_err++; $display("FAIL avg[%0d]: got period=%0d high=%0d timeout=%0b, required %0d/%0d/0",
                          i, obs_q[i].p, obs_q[i].h, obs_q[i].t, exp_q[i].p, exp_q[i].h);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL avg_count: got %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PERIOD_METER_AVG_EN
    test_avg();
`else
    test_div20();
    test_random();
    test_timeout();
    test_coincident();
    test_en_drop();
    test_rst_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
